// File: rtl/ssd_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan capture block: FSM states,
// active-high gfedcba patterns for the hex digits and small anode helpers.
package ssd_scan_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } scan_state_e;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_DP_BIT = 7;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // True when exactly one anode is driven low.
  function automatic logic is_onehot_low(input logic [7:0] an);
    logic [7:0] act;
    act = ~an;
    return (act != 8'h00) && ((act & (act - 8'h01)) == 8'h00);
  endfunction

  // Index of the low anode; only meaningful when is_onehot_low() holds.
  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ssd_scan_capture_seg_to_hex.sv
// Combinational decoder from active-high gfedcba segments to a hex nibble,
// flagging blank digits and patterns that are not a hex glyph.
module seg_to_hex
  import ssd_scan_capture_pkg::*;
(
  input  logic [6:0] segs_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       err_o
);

  // Pattern lookup; unknown glyphs decode to zero with the error flag raised.
  always_comb begin
    nibble_o = 4'h0;
    blank_o  = 1'b0;
    err_o    = 1'b0;
    case (segs_i)
      SEG_0:     nibble_o = 4'h0;
      SEG_1:     nibble_o = 4'h1;
      SEG_2:     nibble_o = 4'h2;
      SEG_3:     nibble_o = 4'h3;
      SEG_4:     nibble_o = 4'h4;
      SEG_5:     nibble_o = 4'h5;
      SEG_6:     nibble_o = 4'h6;
      SEG_7:     nibble_o = 4'h7;
      SEG_8:     nibble_o = 4'h8;
      SEG_9:     nibble_o = 4'h9;
      SEG_A:     nibble_o = 4'hA;
      SEG_B:     nibble_o = 4'hB;
      SEG_C:     nibble_o = 4'hC;
      SEG_D:     nibble_o = 4'hD;
      SEG_E:     nibble_o = 4'hE;
      SEG_F:     nibble_o = 4'hF;
      SEG_BLANK: blank_o  = 1'b1;
      default:   err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_capture.sv
// Receive side of the 8-digit multiplexed seven-segment bus: debounces each
// anode activation, decodes its glyph and publishes complete 32-bit frames.
module ssd_scan_capture
  import ssd_scan_capture_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         TIMEOUT       = 2000000,
  parameter logic [7:0] DIGIT_MASK    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  sd,
  output logic [31:0] value,
  output logic [7:0]  dp_mask,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        stale
);

  localparam int              SCW          = $clog2(SETTLE_CYCLES + 1);
  localparam int              TCW          = $clog2(TIMEOUT + 1);
  localparam logic            FAST_ACCEPT  = (SETTLE_CYCLES == 1);
  localparam logic [SCW-1:0]  SETTLE_LAST  = SCW'(SETTLE_CYCLES);
  localparam logic [TCW-1:0]  TIMEOUT_LAST = TCW'(TIMEOUT);

  logic [7:0]  an_sync_q [SYNC_STAGES];
  logic [7:0]  sd_sync_q [SYNC_STAGES];
  logic [7:0]  an_s;
  logic [7:0]  sd_s;
  logic [15:0] pins_s;
  logic        onehot_s;

  scan_state_e    state_q, state_d, state_s;
  logic [15:0]    snap_q, snap_d;
  logic [SCW-1:0] cnt_q, cnt_d, cnt_s;
  logic           start_s;
  logic           settle_acc_s;
  logic           accept_s;

  logic [31:0]    shadow_q, shadow_d;
  logic [7:0]     shadow_dp_q, shadow_dp_d;
  logic [7:0]     seen_q, seen_d;
  logic [31:0]    value_q, value_d;
  logic [7:0]     dp_mask_q, dp_mask_d;
  logic           frame_valid_q, frame_valid_d;
  logic           decode_err_q, decode_err_d;
  logic           stale_q, stale_d;
  logic [TCW-1:0] tmo_q, tmo_d;

  logic [2:0]     idx_s;
  logic [3:0]     dec_nib_s;
  logic           dec_blank_s;
  logic           dec_err_s;
  logic [3:0]     wr_nib_s;
  logic           frame_fire_s;

  // Input synchroniser; idles at all-high (nothing lit).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        an_sync_q[k] <= 8'hFF;
        sd_sync_q[k] <= 8'hFF;
      end
    end else begin
      an_sync_q[0] <= an;
      sd_sync_q[0] <= sd;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        an_sync_q[k] <= an_sync_q[k-1];
        sd_sync_q[k] <= sd_sync_q[k-1];
      end
    end
  end

  assign an_s     = an_sync_q[SYNC_STAGES-1];
  assign sd_s     = sd_sync_q[SYNC_STAGES-1];
  assign pins_s   = {an_s, sd_s};
  assign onehot_s = is_onehot_low(an_s);

  // Scan FSM: decides when a fresh activation starts and when it has settled.
  always_comb begin
    state_s      = state_q;
    cnt_s        = cnt_q;
    settle_acc_s = 1'b0;
    start_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (onehot_s) start_s = 1'b1;
        else          state_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (pins_s == snap_q) begin
          cnt_s = cnt_q + SCW'(1);
          if (cnt_s == SETTLE_LAST) begin
            settle_acc_s = 1'b1;
            state_s      = ST_CAPTURED;
          end else begin
            state_s = ST_SETTLE;
          end
        end else if (onehot_s) begin
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CAPTURED: begin
        // Only an anode change ends an activation; sd wiggles are ignored here.
        if (an_s != snap_q[15:8]) begin
          if (onehot_s) start_s = 1'b1;
          else          state_s = ST_IDLE;
        end else begin
          state_s = ST_CAPTURED;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Starting an activation snapshots the bus; a one-cycle settle accepts at once.
  always_comb begin
    if (start_s) begin
      snap_d   = pins_s;
      cnt_d    = SCW'(1);
      accept_s = FAST_ACCEPT;
      state_d  = FAST_ACCEPT ? ST_CAPTURED : ST_SETTLE;
    end else begin
      snap_d   = snap_q;
      cnt_d    = cnt_s;
      accept_s = settle_acc_s;
      state_d  = state_s;
    end
  end

  seg_to_hex u_seg_to_hex (
    .segs_i   (~sd_s[6:0]),
    .nibble_o (dec_nib_s),
    .blank_o  (dec_blank_s),
    .err_o    (dec_err_s)
  );

  assign idx_s        = low_index(an_s);
  assign wr_nib_s     = dec_blank_s ? 4'h0 : dec_nib_s;
  assign frame_fire_s = ((seen_q & DIGIT_MASK) == DIGIT_MASK);

  // Shadow frame, frame publication and staleness tracking.
  always_comb begin
    shadow_d      = shadow_q;
    shadow_dp_d   = shadow_dp_q;
    seen_d        = seen_q;
    value_d       = value_q;
    dp_mask_d     = dp_mask_q;
    frame_valid_d = 1'b0;
    decode_err_d  = decode_err_q;
    stale_d       = stale_q;
    tmo_d         = tmo_q;

    if (frame_fire_s) begin
      value_d       = shadow_q;
      dp_mask_d     = shadow_dp_q;
      frame_valid_d = 1'b1;
      seen_d        = 8'h00;
    end else begin
      frame_valid_d = 1'b0;
    end

    if (accept_s) begin
      tmo_d   = '0;
      stale_d = 1'b0;
    end else if (tmo_q != TIMEOUT_LAST) begin
      tmo_d = tmo_q + TCW'(1);
      if (tmo_d == TIMEOUT_LAST) begin
        stale_d = 1'b1;
        seen_d  = 8'h00;
      end else begin
        stale_d = stale_q;
      end
    end else begin
      stale_d = 1'b1;
    end

    // An accept landing on the publish edge starts the next frame.
    if (accept_s) begin
      shadow_d[{idx_s, 2'b00} +: 4] = wr_nib_s;
      shadow_dp_d[idx_s]            = ~sd_s[SEG_DP_BIT];
      seen_d[idx_s]                 = 1'b1;
      decode_err_d                  = decode_err_q | dec_err_s;
    end else begin
      decode_err_d = decode_err_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      snap_q        <= 16'hFFFF;
      cnt_q         <= '0;
      shadow_q      <= 32'h0000_0000;
      shadow_dp_q   <= 8'h00;
      seen_q        <= 8'h00;
      value_q       <= 32'h0000_0000;
      dp_mask_q     <= 8'h00;
      frame_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      stale_q       <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      snap_q        <= snap_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      shadow_dp_q   <= shadow_dp_d;
      seen_q        <= seen_d;
      value_q       <= value_d;
      dp_mask_q     <= dp_mask_d;
      frame_valid_q <= frame_valid_d;
      decode_err_q  <= decode_err_d;
      stale_q       <= stale_d;
      tmo_q         <= tmo_d;
    end
  end

  assign value       = value_q;
  assign dp_mask     = dp_mask_q;
  assign frame_valid = frame_valid_q;
  assign decode_err  = decode_err_q;
  assign stale       = stale_q;

endmodule
